// File: rtl/bcd_scan_pkg.sv
// Shared types and constants for the BCD scan driver.
//   BLANK_CODE  : digit code that the external decoder shows as an unlit digit
//   OVF_CODE    : digit code presented on every digit while overflow is flagged
//   bcd_digit_t : one BCD digit
//   conv_state_t: conversion FSM states
package bcd_scan_pkg;
  localparam logic [3:0] BLANK_CODE = 4'hA;
  localparam logic [3:0] OVF_CODE   = 4'hF;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;
endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction for a single BCD digit: adds 3 when the digit is
// 5 or more, so the following left shift carries correctly into the next digit.
//   d : scratch digit before the shift
//   q : corrected digit (4-bit wrap, no carry out)
module bcd_add3
  import bcd_scan_pkg::*;
(
  input  bcd_digit_t d,
  output bcd_digit_t q
);
  assign q = (d >= 4'd5) ? bcd_digit_t'(d + 4'd3) : d;
endmodule

// File: rtl/bcd_scan_driver.sv
// Binary-to-BCD converter with a multiplexed digit scanner.
// A WIDTH-bit value is converted by sequential double-dabble (one bit per
// cycle) into DIGITS BCD digits. The result is held pending and committed to
// the display buffer only when the scanner wraps to digit 0, so a frame never
// mixes old and new digits.
//   clk, rst : clock, synchronous active-high reset
//   value    : binary value, sampled when load is accepted
//   load     : conversion request (ignored while busy)
//   busy     : conversion in progress
//   ovf      : committed value was >= 10^DIGITS
//   cclr_neg : low while digit 0 is presented (frame marker)
//   dig_sel  : index of the digit on num, 0 = units
//   num      : BCD code of that digit (BLANK_CODE / OVF_CODE as special codes)
// Optional build macro LZ_BLANK_EN: blank leading zeros above the most
// significant non-zero digit; digit 0 is always shown.
module bcd_scan_driver
  import bcd_scan_pkg::*;
#(
  parameter  int WIDTH    = 32,
  parameter  int DIGITS   = 8,
  parameter  int SCAN_DIV = 1,
  localparam int SELW     = (DIGITS > 2) ? $clog2(DIGITS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] value,
  input  logic             load,
  output logic             busy,
  output logic             ovf,
  output logic             cclr_neg,
  output logic [SELW-1:0]  dig_sel,
  output logic [3:0]       num
);
  localparam int CW = $clog2(WIDTH);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  conv_state_t                state, state_nxt;
  logic [WIDTH-1:0]           bin;
  logic [CW-1:0]              bit_cnt;
  bcd_digit_t [DIGITS-1:0]    scr, scr_add3, pend_buf, disp_buf, commit_buf, buf_nxt;
  logic [4*DIGITS:0]          shifted;
  logic                       ovf_scr, pend_ovf, pending;
  logic [DW-1:0]              div;
  logic                       div_tc, wrap, commit, ovf_nxt;
  logic [SELW-1:0]            sel_nxt;

  // ---------------- conversion datapath ----------------
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (.d(scr[g]), .q(scr_add3[g]));
  end

  // Top bit of the shifted vector is what falls out of the highest digit.
  assign shifted = {scr_add3, bin[WIDTH-1]};
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (load) state_nxt = SHIFT;
      SHIFT:   if (bit_cnt == CW'(WIDTH-1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bin      <= '0;
      bit_cnt  <= '0;
      scr      <= '0;
      ovf_scr  <= 1'b0;
      pend_buf <= '0;
      pend_ovf <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (load) begin
          bin     <= value;
          scr     <= '0;
          ovf_scr <= 1'b0;
          bit_cnt <= '0;
        end
        SHIFT: begin
          scr     <= shifted[4*DIGITS-1:0];
          ovf_scr <= ovf_scr | shifted[4*DIGITS];
          bin     <= bin << 1;
          bit_cnt <= bit_cnt + 1'b1;
        end
        DONE: begin
          pend_buf <= scr;
          pend_ovf <= ovf_scr;
        end
        default: ;
      endcase
    end
  end

  // ---------------- commit-time formatting ----------------
`ifdef LZ_BLANK_EN
  logic lz_lead;
  always_comb begin
    commit_buf = pend_buf;
    lz_lead    = !pend_ovf;       // overflow frames are all OVF_CODE anyway
    for (int i = DIGITS-1; i > 0; i--) begin
      if (pend_buf[i] != 4'd0) lz_lead = 1'b0;
      if (lz_lead) commit_buf[i] = BLANK_CODE;
    end
  end
`else
  assign commit_buf = pend_buf;
`endif

  // ---------------- scanner ----------------
  assign div_tc = (div == DW'(SCAN_DIV-1));
  assign wrap   = div_tc && (dig_sel == SELW'(DIGITS-1));
  assign commit = wrap && pending;

  // num/cclr_neg are computed from the post-edge selection and buffer so they
  // line up with dig_sel, and digit 0 of a committing frame shows new data.
  always_comb begin
    sel_nxt = dig_sel;
    if (div_tc) sel_nxt = wrap ? '0 : dig_sel + 1'b1;
    buf_nxt = commit ? commit_buf : disp_buf;
    ovf_nxt = commit ? pend_ovf : ovf;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div      <= '0;
      dig_sel  <= '0;
      num      <= 4'd0;
      cclr_neg <= 1'b0;
      disp_buf <= '0;
      ovf      <= 1'b0;
      pending  <= 1'b0;
    end else begin
      div      <= div_tc ? '0 : div + 1'b1;
      dig_sel  <= sel_nxt;
      disp_buf <= buf_nxt;
      ovf      <= ovf_nxt;
      num      <= ovf_nxt ? OVF_CODE : buf_nxt[sel_nxt];
      cclr_neg <= (sel_nxt != '0);
      // A result landing on the wrap edge keeps pending set for the next frame.
      if (state == DONE) pending <= 1'b1;
      else if (commit)   pending <= 1'b0;
    end
  end
endmodule
